// File: rtl/way_halt_fill_ctrl_pkg.sv
// Shared sizing and FSM encoding for the way-halting refill controller.
// Imported by the interface, the victim selector and the controller top.
package way_halt_fill_ctrl_pkg;

  localparam int NUM_WAYS = 8;
  localparam int HALT_W   = 4;
  localparam int TAG_W    = 16;
  localparam int WAY_W    = $clog2(NUM_WAYS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } fill_state_t;

endpackage

// File: rtl/way_halt_fill_ctrl_if.sv
// Miss-side, memory-side and halt-array-side signals of the refill controller.
// The master modport is the controller's view; slave is the surrounding logic.
interface way_halt_fill_ctrl_if;
  import way_halt_fill_ctrl_pkg::*;

  logic                miss_valid;
  logic                miss_ready;
  logic [TAG_W-1:0]    miss_tag;
  logic                flush;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [TAG_W-1:0]    mem_req_tag;
  logic [WAY_W-1:0]    mem_req_way;
  logic                mem_resp_valid;
  logic                mem_resp_err;
  logic [NUM_WAYS-1:0] halt_we;
  logic [HALT_W-1:0]   halt_tag_write;
  logic [NUM_WAYS-1:0] way_valid;
  logic                fill_done;
  logic                fill_err;
  logic                busy;

  modport master (
    input  miss_valid, miss_tag, flush, mem_req_ready, mem_resp_valid, mem_resp_err,
    output miss_ready, mem_req_valid, mem_req_tag, mem_req_way,
    output halt_we, halt_tag_write, way_valid, fill_done, fill_err, busy
  );

  modport slave (
    output miss_valid, miss_tag, flush, mem_req_ready, mem_resp_valid, mem_resp_err,
    input  miss_ready, mem_req_valid, mem_req_tag, mem_req_way,
    input  halt_we, halt_tag_write, way_valid, fill_done, fill_err, busy
  );

endinterface

// File: rtl/way_halt_fill_ctrl_victim_select.sv
// Victim choice: lowest-index invalid way, otherwise the round-robin pointer.
// from_rr tells the controller whether the pointer should advance after the fill.
module way_victim_select
  import way_halt_fill_ctrl_pkg::*;
(
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [WAY_W-1:0]    rr_ptr,
  output logic [WAY_W-1:0]    victim,
  output logic                from_rr
);

  // Scan from the top down so the lowest invalid index is the last one written.
  always_comb begin
    victim  = rr_ptr;
    from_rr = 1'b1;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        victim  = WAY_W'(i);
        from_rr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/way_halt_fill_ctrl.sv
// Refill controller for the way-halting tag array: picks a victim on a miss,
// fetches the line over valid/ready and writes the halt tag for one cycle.
module way_halt_fill_ctrl
  import way_halt_fill_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  way_halt_fill_ctrl_if.master bus
);

  fill_state_t         state_reg;
  logic [WAY_W-1:0]    rr_ptr_reg;
  logic                from_rr_reg;
  logic [TAG_W-1:0]    req_tag_reg;
  logic [WAY_W-1:0]    req_way_reg;
  logic                req_valid_reg;
  logic [NUM_WAYS-1:0] way_valid_reg;
  logic [NUM_WAYS-1:0] halt_we_reg;
  logic [HALT_W-1:0]   halt_tag_reg;
  logic                fill_done_reg;
  logic                fill_err_reg;
  logic                busy_reg;

  logic [WAY_W-1:0]    victim_next;
  logic                from_rr_next;
  logic [WAY_W-1:0]    rr_ptr_next;
  logic                miss_accept;

  way_victim_select u_victim (
    .way_valid (way_valid_reg),
    .rr_ptr    (rr_ptr_reg),
    .victim    (victim_next),
    .from_rr   (from_rr_next)
  );

  assign bus.miss_ready = (state_reg == IDLE) && !bus.flush;
  assign miss_accept    = bus.miss_valid && bus.miss_ready;
  assign rr_ptr_next    = (req_way_reg == WAY_W'(NUM_WAYS - 1)) ? '0 : req_way_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      from_rr_reg   <= 1'b0;
      req_tag_reg   <= '0;
      req_way_reg   <= '0;
      req_valid_reg <= 1'b0;
      way_valid_reg <= '0;
      halt_we_reg   <= '0;
      halt_tag_reg  <= '0;
      fill_done_reg <= 1'b0;
      fill_err_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      // Strobes and write data are single-cycle unless re-armed below.
      halt_we_reg   <= '0;
      halt_tag_reg  <= '0;
      fill_done_reg <= 1'b0;
      fill_err_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.flush) begin
            way_valid_reg <= '0;
            rr_ptr_reg    <= '0;
          end else if (miss_accept) begin
            req_tag_reg   <= bus.miss_tag;
            req_way_reg   <= victim_next;
            from_rr_reg   <= from_rr_next;
            req_valid_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.mem_req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end

        WAIT: begin
          if (bus.mem_resp_valid) begin
            if (bus.mem_resp_err) begin
              fill_err_reg <= 1'b1;
              busy_reg     <= 1'b0;
              state_reg    <= IDLE;
            end else begin
              // Arm the write so it is held for the whole WRITE cycle.
              halt_we_reg                <= NUM_WAYS'(1) << req_way_reg;
              halt_tag_reg               <= req_tag_reg[HALT_W-1:0];
              way_valid_reg[req_way_reg] <= 1'b1;
              fill_done_reg              <= 1'b1;
              if (from_rr_reg) begin
                rr_ptr_reg <= rr_ptr_next;
              end
              state_reg <= WRITE;
            end
          end
        end

        WRITE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy_reg      <= 1'b0;
          req_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_valid  = req_valid_reg;
  assign bus.mem_req_tag    = req_tag_reg;
  assign bus.mem_req_way    = req_way_reg;
  assign bus.halt_we        = halt_we_reg;
  assign bus.halt_tag_write = halt_tag_reg;
  assign bus.way_valid      = way_valid_reg;
  assign bus.fill_done      = fill_done_reg;
  assign bus.fill_err       = fill_err_reg;
  assign bus.busy           = busy_reg;

endmodule

// File: tb/tb_way_halt_fill_ctrl.sv
// Directed bench for way_halt_fill_ctrl: drives and samples on the falling edge,
// expected ways and halt-write values are hand-derived per scenario.
module tb_way_halt_fill_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [7:0] exp_valid;

  way_halt_fill_ctrl_if bus();

  way_halt_fill_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts and ends on a falling edge with the controller in IDLE.
  task automatic run_fill(input logic [15:0] tag, input logic [2:0] exp_way,
                          input int stall, input bit err);
    logic [7:0] oh;
    oh = 8'h01 << exp_way;
    bus.miss_valid = 1'b1;
    bus.miss_tag   = tag;
    #1;
    checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL miss_ready_idle got %b exp 1", bus.miss_ready); end
    @(negedge clk);
    bus.miss_valid = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      bus.mem_resp_valid = 1'b0;
      checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL req_valid got %b exp 1", bus.mem_req_valid); end
      checks++; if (bus.mem_req_way !== exp_way) begin errors++; $display("FAIL req_way got %0d exp %0d", bus.mem_req_way, exp_way); end
      checks++; if (bus.mem_req_tag !== tag) begin errors++; $display("FAIL req_tag got %h exp %h", bus.mem_req_tag, tag); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_issue got %b exp 1", bus.busy); end
      checks++; if (bus.fill_err !== 1'b0) begin errors++; $display("FAIL fill_err_issue got %b exp 0", bus.fill_err); end
      bus.mem_req_ready  = (i == stall);
      bus.mem_resp_valid = (stall > 0) && (i == 0);
      @(negedge clk);
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL req_valid_wait got %b exp 0", bus.mem_req_valid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_wait got %b exp 1", bus.busy); end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_err   = err;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_err   = 1'b0;
    if (!err) begin
      checks++; if (bus.halt_we !== oh) begin errors++; $display("FAIL halt_we got %h exp %h", bus.halt_we, oh); end
      checks++; if (bus.halt_tag_write !== tag[3:0]) begin errors++; $display("FAIL halt_tag got %h exp %h", bus.halt_tag_write, tag[3:0]); end
      checks++; if (bus.fill_done !== 1'b1) begin errors++; $display("FAIL fill_done got %b exp 1", bus.fill_done); end
      exp_valid = exp_valid | oh;
      checks++; if (bus.way_valid !== exp_valid) begin errors++; $display("FAIL way_valid_write got %h exp %h", bus.way_valid, exp_valid); end
      @(negedge clk);
      checks++; if (bus.halt_we !== 8'h00) begin errors++; $display("FAIL halt_we_after got %h exp 00", bus.halt_we); end
      checks++; if (bus.halt_tag_write !== 4'h0) begin errors++; $display("FAIL halt_tag_after got %h exp 0", bus.halt_tag_write); end
      checks++; if (bus.fill_done !== 1'b0) begin errors++; $display("FAIL fill_done_after got %b exp 0", bus.fill_done); end
    end else begin
      checks++; if (bus.fill_err !== 1'b1) begin errors++; $display("FAIL fill_err got %b exp 1", bus.fill_err); end
      checks++; if (bus.halt_we !== 8'h00) begin errors++; $display("FAIL halt_we_err got %h exp 00", bus.halt_we); end
      checks++; if (bus.fill_done !== 1'b0) begin errors++; $display("FAIL fill_done_err got %b exp 0", bus.fill_done); end
      checks++; if (bus.way_valid !== exp_valid) begin errors++; $display("FAIL way_valid_err got %h exp %h", bus.way_valid, exp_valid); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_end got %b exp 0", bus.busy); end
    checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL miss_ready_end got %b exp 1", bus.miss_ready); end
    $display("fill tag=%h way=%0d stall=%0d err=%0b way_valid=%h", tag, exp_way, stall, err, bus.way_valid);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_valid = 8'h00;
    checks++; if (bus.way_valid !== 8'h00) begin errors++; $display("FAIL rst_way_valid got %h exp 00", bus.way_valid); end
    checks++; if (bus.halt_we !== 8'h00) begin errors++; $display("FAIL rst_halt_we got %h exp 00", bus.halt_we); end
    checks++; if (bus.halt_tag_write !== 4'h0) begin errors++; $display("FAIL rst_halt_tag got %h exp 0", bus.halt_tag_write); end
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", bus.mem_req_valid); end
    checks++; if ({bus.fill_done, bus.fill_err, bus.busy} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {bus.fill_done, bus.fill_err, bus.busy}); end
    checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL rst_miss_ready got %b exp 1", bus.miss_ready); end
    $display("reset way_valid=%h busy=%b", bus.way_valid, bus.busy);
  endtask

  task automatic test_first_fill();
    run_fill(16'h1235, 3'd0, 0, 1'b0);
  endtask

  task automatic test_sequential();
    test_reset();
    for (int i = 0; i < 8; i++) run_fill(16'(i), 3'(i), 0, 1'b0);
    checks++; if (bus.way_valid !== 8'hFF) begin errors++; $display("FAIL all_valid got %h exp FF", bus.way_valid); end
    run_fill(16'h000A, 3'd0, 0, 1'b0);
    run_fill(16'h000B, 3'd1, 0, 1'b0);
  endtask

  task automatic test_rr_wrap();
    for (int i = 2; i < 7; i++) run_fill(16'h0020 + 16'(i), 3'(i), 0, 1'b0);
    run_fill(16'h002F, 3'd7, 0, 1'b0);
    run_fill(16'h0030, 3'd0, 0, 1'b0);
  endtask

  task automatic test_ready_stall();
    run_fill(16'hBEEF, 3'd1, 5, 1'b0);
  endtask

  task automatic test_error();
    run_fill(16'h4444, 3'd2, 0, 1'b1);
    run_fill(16'h4445, 3'd2, 0, 1'b0);
  endtask

  task automatic test_flush();
    bus.flush      = 1'b1;
    bus.miss_valid = 1'b1;
    bus.miss_tag   = 16'h9999;
    #1;
    checks++; if (bus.miss_ready !== 1'b0) begin errors++; $display("FAIL flush_miss_ready got %b exp 0", bus.miss_ready); end
    @(negedge clk);
    bus.flush      = 1'b0;
    bus.miss_valid = 1'b0;
    exp_valid      = 8'h00;
    checks++; if (bus.way_valid !== 8'h00) begin errors++; $display("FAIL flush_way_valid got %h exp 00", bus.way_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", bus.busy); end
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    checks++; if ({bus.busy, bus.fill_done, bus.fill_err, bus.mem_req_valid} !== 4'b0000) begin errors++; $display("FAIL stray_resp got %b exp 0000", {bus.busy, bus.fill_done, bus.fill_err, bus.mem_req_valid}); end
    $display("flush way_valid=%h", bus.way_valid);
    for (int i = 0; i < 8; i++) run_fill(16'h0050 + 16'(i), 3'(i), 0, 1'b0);
    run_fill(16'h005A, 3'd0, 0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    bus.miss_valid = 1'b1;
    bus.miss_tag   = 16'h7777;
    @(negedge clk);
    bus.miss_valid    = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rw_busy got %b exp 1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.way_valid !== 8'h00) begin errors++; $display("FAIL rw_way_valid got %h exp 00", bus.way_valid); end
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_req_valid got %b exp 0", bus.mem_req_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rw_busy_after got %b exp 0", bus.busy); end
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.halt_we !== 8'h00) begin errors++; $display("FAIL rw_halt_we got %h exp 00", bus.halt_we); end
    checks++; if ({bus.fill_done, bus.busy} !== 2'b00) begin errors++; $display("FAIL rw_late_resp got %b exp 00", {bus.fill_done, bus.busy}); end
    checks++; if (bus.way_valid !== 8'h00) begin errors++; $display("FAIL rw_way_valid_late got %h exp 00", bus.way_valid); end
    $display("reset_in_wait way_valid=%h busy=%b", bus.way_valid, bus.busy);
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    exp_valid          = 8'h00;
    reset              = 1'b1;
    bus.miss_valid     = 1'b0;
    bus.miss_tag       = '0;
    bus.flush          = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_err   = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_fill();
    test_sequential();
    test_rr_wrap();
    test_ready_stall();
    test_error();
    test_flush();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/way_halt_fill_ctrl.md
Name: way_halt_fill_ctrl

Overview:
- Refill-side controller for the way-halting tag array; it produces that array's per-way write enables and the halt-tag write data.
- On a cache miss it selects a victim way, requests the line from memory over a valid/ready interface, and waits for the response.
- On a good response it writes the low tag bits into the victim's halt-tag register and marks the way valid.
- Sits between the miss detector and the 8-way halt tag array / line-fill path.

Parameters:
NUM_WAYS, 8, number of ways (one halt-tag register each)
HALT_W, 4, halt-tag width (low bits of the full tag)
TAG_W, 16, full tag width carried to memory

Ports:
clk  in  1  clock, rising-edge
reset  in  1  reset, synchronous, active-high
miss_valid  in  1  miss request present
miss_ready  out  1  controller can accept a miss
miss_tag  in  TAG_W  full tag of the missing line
flush  in  1  invalidate all ways (honoured only in IDLE)
mem_req_valid  out  1  refill request to memory
mem_req_ready  in  1  memory accepts the request
mem_req_tag  out  TAG_W  tag being refilled
mem_req_way  out  3  victim way index
mem_resp_valid  in  1  refill response, single-cycle pulse
mem_resp_err  in  1  response carries an error (qualified by mem_resp_valid)
halt_we  out  NUM_WAYS  one-hot halt-tag array write enable
halt_tag_write  out  HALT_W  halt-tag write data
way_valid  out  NUM_WAYS  per-way valid bits
fill_done  out  1  one-cycle pulse on successful fill
fill_err  out  1  one-cycle pulse on errored fill
busy  out  1  state is not IDLE

Behaviour:
- All outputs are registered except miss_ready.
- miss_ready = (state==IDLE) & ~flush.
- Reset values: state=IDLE; way_valid=0; rr_ptr=0; halt_we=0; halt_tag_write=0; mem_req_valid=0; fill_done=0; fill_err=0; busy=0.
- Reset mid-fill: aborts the fill, drops mem_req_valid, clears way_valid. No write is performed.
- States: IDLE, ISSUE, WAIT, WRITE.
- IDLE, miss accepted (miss_valid & miss_ready):
  - latch miss_tag;
  - victim = lowest-index way with way_valid=0; if all ways are valid, victim = rr_ptr;
  - record whether the victim came from the round-robin path;
  - next state ISSUE.
- IDLE with flush=1: way_valid<=0 and rr_ptr<=0 next cycle; a miss presented in the same cycle is not accepted.
- ISSUE:
  - mem_req_valid=1; mem_req_tag and mem_req_way hold stable until mem_req_ready=1;
  - the handshake cycle moves to WAIT; mem_req_valid is 0 from WAIT onward.
- WAIT:
  - mem_resp_valid=1 with mem_resp_err=0 -> WRITE;
  - mem_resp_valid=1 with mem_resp_err=1 -> IDLE with fill_err pulse. No write; way_valid and rr_ptr unchanged.
- WRITE, exactly one cycle:
  - halt_we = one-hot(victim); halt_tag_write = latched_tag[HALT_W-1:0];
  - way_valid[victim] <= 1; fill_done pulses;
  - rr_ptr <= (victim+1) mod NUM_WAYS, only when the victim came from the round-robin path; rr_ptr wraps 7->0;
  - next state IDLE.
- halt_we is asserted for a full clock period. The array samples on the following falling edge and sees stable data.
- halt_tag_write = 0 outside WRITE.
- Minimum latency: accept at cycle 0; ISSUE at cycle 1 with ready=1; response at cycle 2; WRITE at cycle 3; IDLE at cycle 4.
- Stray mem_resp_valid in IDLE or ISSUE is ignored.
- Back-to-back misses: the next miss is accepted in the first IDLE cycle after WRITE or after an error.
- A flush asserted while busy has no effect (it is not deferred).

Decomposition:
- Shared package holds:
  - NUM_WAYS, HALT_W, TAG_W;
  - way index width = clog2(NUM_WAYS);
  - FSM state enum (IDLE, ISSUE, WAIT, WRITE).
- One sub-module, way_victim_select, combinational:
  - inputs way_valid and rr_ptr;
  - outputs victim index and a from_rr flag;
  - lowest-index-invalid priority encoder with round-robin fallback.

Test Plan:
- After reset, miss tag 0x1235 with ready=1 and good response -> mem_req_way=0, halt_we=0x01, halt_tag_write=0x5, way_valid=0x01, fill_done at cycle 3, rr_ptr=0.
- 8 consecutive fills, tags 0x0..0x7 -> ways 0..7 in order; way_valid=0xFF; the 9th fill (tag 0xA) goes to way 0 with halt_we=0x01; the 10th goes to way 1.
- All ways valid, rr_ptr=7, fill -> halt_we=0x80, then rr_ptr=0 (wrap).
- mem_req_ready held low for 5 cycles -> mem_req_valid, tag and way stay stable; the FSM enters WAIT only after ready.
- Error response -> fill_err pulse, halt_we stays 0, way_valid and rr_ptr unchanged, miss_ready high next cycle.
- flush together with miss_valid in IDLE -> miss not accepted, way_valid=0, rr_ptr=0. Reset asserted in WAIT -> IDLE, way_valid=0, mem_req_valid=0, and a later response is ignored.
